comparator_bist: RTL and testbench

COMPARATOR_BIST -- requirements
Module: comparator_bist

---
 rtl/comparator_pkg.sv | 23 ++
 rtl/comparator_bist_if.sv | 16 +
 rtl/cmp_golden.sv | 27 ++
 rtl/comparator_bist.sv | 154 +++++++++++++++
 tb/tb_comparator_bist.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg -- shared types and constants for the comparator BIST.
//   state_e       : sequencer state encoding
//   MODE_*        : golden-function encodings carried on cmp_mode
//   SETTLE_MAX    : largest supported settle delay (fits SETTLE_W bits)
package comparator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_EQ = 2'b00;  // A == B
  localparam logic [1:0] MODE_GT = 2'b01;  // A >  B
  localparam logic [1:0] MODE_LT = 2'b10;  // A <  B
  localparam logic [1:0] MODE_GE = 2'b11;  // A >= B

  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = 4;

endpackage

// File: rtl/comparator_bist_if.sv
// comparator_bist_if -- stimulus/response bus between the BIST engine and
// the comparator under test.
//   dut_a, dut_b : operands driven by the BIST (master)
//   dut_f        : comparator result returned by the device (slave)
interface comparator_bist_if #(
  parameter int WIDTH = 2
);

  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_f;

  modport master (output dut_a, output dut_b, input dut_f);
  modport slave  (input dut_a, input dut_b, output dut_f);

endinterface

// File: rtl/cmp_golden.sv
// cmp_golden -- combinational reference comparator, unsigned operands.
//   a, b : operands
//   mode : golden function select (MODE_EQ/GT/LT/GE)
//   f    : expected comparator result
module cmp_golden
  import comparator_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             f
);

  always_comb begin
    f = 1'b0;
    case (mode)
      MODE_EQ: f = (a == b);
      MODE_GT: f = (a >  b);
      MODE_LT: f = (a <  b);
      MODE_GE: f = (a >= b);
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/comparator_bist.sv
// comparator_bist -- exhaustive self-test engine for a WIDTH-bit comparator.
// Sweeps every {A,B} pair, waits SETTLE cycles per vector, checks dut_f
// against the golden function latched at start, and reports the result.
//   clk, rst_n        : clock, async active-low reset
//   start             : run request, honoured only in IDLE
//   cmp_mode          : golden function, latched at start
//   dut_a, dut_b      : registered operands to the device under test
//   dut_f             : device result
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   pass              : last completed run had no mismatches
//   err_count         : mismatch count of current or last run
//   first_fail_vec    : {A,B} of the first mismatch
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start; results of last run held
// ST_DRIVE | operands for vec applied
// ST_WAIT  | settle delay, SETTLE cycles (skipped when SETTLE=0)
// ST_CHECK | dut_f compared with golden; advance or finish
// ST_DONE  | done pulse, back to IDLE
module comparator_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cmp_mode,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail_vec
);

  localparam int VW = 2 * WIDTH;
  // Out-of-range settle requests are clamped to what the wait timer holds.
  localparam int SETTLE_EFF = (SETTLE > SETTLE_MAX) ? SETTLE_MAX :
                              (SETTLE < 0) ? 0 : SETTLE;
  // Down-counter load: terminal count 0 is reached after SETTLE_EFF cycles.
  localparam logic [SETTLE_W-1:0] WAIT_LD =
    (SETTLE_EFF > 0) ? SETTLE_W'(SETTLE_EFF - 1) : '0;
  localparam logic [VW-1:0] VEC_LAST = '1;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [VW-1:0]       vec_q, vec_d;
  logic [VW:0]         err_q, err_d;
  logic [VW-1:0]       ffv_q, ffv_d;
  logic                pass_q, pass_d;
  logic [SETTLE_W-1:0] wait_q, wait_d;
  logic                golden_f;
  logic                mismatch;

  cmp_golden #(.WIDTH(WIDTH)) u_golden (
    .a    (vec_q[VW-1:WIDTH]),
    .b    (vec_q[WIDTH-1:0]),
    .mode (mode_q),
    .f    (golden_f)
  );

  assign mismatch = (dut_f != golden_f);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: state_d = (SETTLE_EFF == 0) ? ST_CHECK : ST_WAIT;
      ST_WAIT:  if (wait_q == '0) state_d = ST_CHECK;
      ST_CHECK: state_d = (vec_q == VEC_LAST) ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
    mode_d = mode_q;
    vec_d  = vec_q;
    err_d  = err_q;
    ffv_d  = ffv_q;
    pass_d = pass_q;
    wait_d = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = cmp_mode;
          vec_d  = '0;
          err_d  = '0;
          ffv_d  = '0;
          pass_d = 1'b0;
        end
      end
      ST_DRIVE: wait_d = WAIT_LD;
      ST_WAIT:  if (wait_q != '0) wait_d = wait_q - 1'b1;
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) ffv_d = vec_q;
        end
        // pass is resolved on the last vector so it is valid alongside done.
        if (vec_q != VEC_LAST) begin
          vec_d = vec_q + 1'b1;
        end else begin
          pass_d = (err_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      vec_q  <= '0;
      err_q  <= '0;
      ffv_q  <= '0;
      pass_q <= 1'b0;
      wait_q <= '0;
    end else begin
      mode_q <= mode_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      ffv_q  <= ffv_d;
      pass_q <= pass_d;
      wait_q <= wait_d;
    end
  end

  assign dut_a          = vec_q[VW-1:WIDTH];
  assign dut_b          = vec_q[WIDTH-1:0];
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_comparator_bist.sv
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start0;
  logic [1:0] mode1, mode0;
  logic       busy1, done1, pass1, busy0, done0, pass0;
  logic [4:0] err1, err0;
  logic [3:0] ffv1, ffv0;

  logic [1:0] model_mode;
  logic       fault_en;
  logic       f0_val;

  int n_checks = 0;
  int n_fail   = 0;

  comparator_bist_if #(.WIDTH(2)) if1 ();
  comparator_bist_if #(.WIDTH(2)) if0 ();

  comparator_bist #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmp_mode(mode1),
    .dut_a(if1.dut_a), .dut_b(if1.dut_b), .dut_f(if1.dut_f),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1)
  );

  comparator_bist #(.WIDTH(2), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmp_mode(mode0),
    .dut_a(if0.dut_a), .dut_b(if0.dut_b), .dut_f(if0.dut_f),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0)
  );

  // Behavioural comparator under test, optionally faulted at {A,B}=6 and 9.
  function automatic logic dev_cmp(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
    case (m)
      2'b00:   return a == b;
      2'b01:   return a > b;
      2'b10:   return a < b;
      default: return a >= b;
    endcase
  endfunction

  assign if1.dut_f = dev_cmp(model_mode, if1.dut_a, if1.dut_b) ^
                     (fault_en && ({if1.dut_a, if1.dut_b} == 4'd6 ||
                                   {if1.dut_a, if1.dut_b} == 4'd9));
  assign if0.dut_f = f0_val;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns at the sample just after the accepting edge (j = 0).
  task automatic pulse_start1(input logic [1:0] m);
    repeat (2) step;
    @(negedge clk);
    mode1  = m;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic pulse_start0(input logic [1:0] m);
    repeat (2) step;
    @(negedge clk);
    mode0  = m;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
  endtask

  task automatic wait_done1(input int budget, output int lat);
    lat = -1;
    for (int j = 0; j <= budget; j++) begin
      if (done1) begin
        lat = j;
        break;
      end
      step;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step;
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done1); end
    n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass1); end
    n_checks++; if (err1 !== 5'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err1); end
    n_checks++; if ({if1.dut_a, if1.dut_b, ffv1} !== 8'd0) begin n_fail++; $display("FAIL reset_vec got %h want 00", {if1.dut_a, if1.dut_b, ffv1}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step;
    n_checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b%b want 00", busy1, busy0); end
  endtask

  task automatic test_sweep;
    int lat, bad, busy_bad;
    bad = 0; busy_bad = 0; lat = -1;
    fault_en = 1'b0; model_mode = 2'b01;
    pulse_start1(2'b01);
    for (int j = 0; j <= 60; j++) begin
      if (done1) begin
        lat = j;
        break;
      end
      if ({if1.dut_a, if1.dut_b} !== 4'(j / 3)) bad++;
      if (busy1 !== 1'b1) busy_bad++;
      step;
    end
    n_checks++; if (lat != 48) begin n_fail++; $display("FAIL sweep_latency got %0d want 48", lat); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sweep_order got %0d bad samples want 0", bad); end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL sweep_busy got %0d low samples want 0", busy_bad); end
    n_checks++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL sweep_pass got %b want 1", pass1); end
    n_checks++; if (err1 !== 5'd0) begin n_fail++; $display("FAIL sweep_err got %0d want 0", err1); end
    n_checks++; if ({if1.dut_a, if1.dut_b} !== 4'd15) begin n_fail++; $display("FAIL sweep_nowrap got %0d want 15", {if1.dut_a, if1.dut_b}); end
    step;
    n_checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL sweep_done_pulse got done=%b busy=%b want 0 0", done1, busy1); end
    n_checks++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL sweep_pass_hold got %b want 1", pass1); end
  endtask

  task automatic test_fault;
    int lat;
    fault_en = 1'b1; model_mode = 2'b01;
    pulse_start1(2'b01);
    n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL fault_pass_cleared got %b want 0", pass1); end
    wait_done1(60, lat);
    n_checks++; if (lat != 48) begin n_fail++; $display("FAIL fault_latency got %0d want 48", lat); end
    n_checks++; if (err1 !== 5'd2) begin n_fail++; $display("FAIL fault_err got %0d want 2", err1); end
    n_checks++; if (ffv1 !== 4'd6) begin n_fail++; $display("FAIL fault_first got %0d want 6", ffv1); end
    n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL fault_pass got %b want 0", pass1); end
    repeat (4) step;
    n_checks++; if (err1 !== 5'd2 || ffv1 !== 4'd6) begin n_fail++; $display("FAIL fault_hold got err=%0d first=%0d want 2 6", err1, ffv1); end
    fault_en = 1'b0;
  endtask

  task automatic test_settle0;
    int lat;
    lat = -1;
    f0_val = 1'b0;
    pulse_start0(2'b00);
    for (int j = 0; j <= 50; j++) begin
      if (done0) begin
        lat = j;
        break;
      end
      step;
    end
    n_checks++; if (lat != 32) begin n_fail++; $display("FAIL settle0_latency got %0d want 32", lat); end
    n_checks++; if (err0 !== 5'd4) begin n_fail++; $display("FAIL settle0_err got %0d want 4", err0); end
    n_checks++; if (ffv0 !== 4'd0) begin n_fail++; $display("FAIL settle0_first got %0d want 0", ffv0); end
    n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL settle0_pass got %b want 0", pass0); end
  endtask

  task automatic test_start_ignore;
    int lat, done_cnt;
    lat = -1; done_cnt = 0;
    fault_en = 1'b0; model_mode = 2'b01;
    pulse_start1(2'b01);
    for (int j = 0; j <= 60; j++) begin
      if (j == 9)  start1 = 1'b1;
      if (j == 10) start1 = 1'b0;
      if (j == 47) start1 = 1'b1;
      if (j == 49) start1 = 1'b0;
      if (done1) begin
        done_cnt++;
        if (lat < 0) lat = j;
      end
      step;
    end
    n_checks++; if (lat != 48) begin n_fail++; $display("FAIL restart_latency got %0d want 48", lat); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_count got %0d want 1", done_cnt); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL restart_idle got busy=%b want 0", busy1); end
    n_checks++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL restart_pass got %b want 1", pass1); end
  endtask

  task automatic test_mode_latch;
    int lat;
    model_mode = 2'b10;
    pulse_start1(2'b10);
    repeat (5) step;
    mode1 = 2'b00;
    wait_done1(60, lat);
    n_checks++; if (err1 !== 5'd0 || pass1 !== 1'b1) begin n_fail++; $display("FAIL latch_lt got err=%0d pass=%b want 0 1", err1, pass1); end
    // A>B device checked as A>=B: every equal pair mismatches.
    model_mode = 2'b01;
    pulse_start1(2'b11);
    repeat (7) step;
    mode1 = 2'b01;
    wait_done1(60, lat);
    n_checks++; if (err1 !== 5'd4) begin n_fail++; $display("FAIL latch_ge_err got %0d want 4", err1); end
    n_checks++; if (ffv1 !== 4'd0 || pass1 !== 1'b0) begin n_fail++; $display("FAIL latch_ge_first got first=%0d pass=%b want 0 0", ffv1, pass1); end
  endtask

  task automatic test_reset_midrun;
    int lat, hit, done_seen, busy_seen;
    hit = 0; done_seen = 0; busy_seen = 0;
    fault_en = 1'b1; model_mode = 2'b01;
    pulse_start1(2'b01);
    for (int j = 0; j <= 40; j++) begin
      if ({if1.dut_a, if1.dut_b} == 4'd7) begin
        hit = 1;
        break;
      end
      step;
    end
    n_checks++; if (hit != 1 || err1 !== 5'd1) begin n_fail++; $display("FAIL abort_reach_vec7 got hit=%0d err=%0d want 1 1", hit, err1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy1, done1, pass1} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got %b want 000", {busy1, done1, pass1}); end
    n_checks++; if (err1 !== 5'd0 || ffv1 !== 4'd0) begin n_fail++; $display("FAIL abort_results got err=%0d first=%0d want 0 0", err1, ffv1); end
    n_checks++; if ({if1.dut_a, if1.dut_b} !== 4'd0) begin n_fail++; $display("FAIL abort_operands got %0d want 0", {if1.dut_a, if1.dut_b}); end
    step;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 60; j++) begin
      step;
      if (done1) done_seen++;
      if (busy1) busy_seen++;
    end
    n_checks++; if (done_seen != 0 || busy_seen != 0) begin n_fail++; $display("FAIL abort_no_restart got done=%0d busy=%0d want 0 0", done_seen, busy_seen); end
    fault_en = 1'b0;
    pulse_start1(2'b01);
    wait_done1(60, lat);
    n_checks++; if (lat != 48 || pass1 !== 1'b1 || err1 !== 5'd0) begin n_fail++; $display("FAIL abort_rerun got lat=%0d pass=%b err=%0d want 48 1 0", lat, pass1, err1); end
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0;
    mode1 = 2'b00; mode0 = 2'b00;
    model_mode = 2'b01; fault_en = 1'b0; f0_val = 1'b0;
    test_reset;
    test_sweep;
    test_fault;
    test_settle0;
    test_start_ignore;
    test_mode_latch;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
